// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg: shared types and constants for the host-side
// command transmitter talking to the knight robot.
package remote_comm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TX_HI,
        TX_LO,
        DONE
    } state_t;

    // 19200 baud at 50 MHz
    localparam int DEF_BAUD_DIV = 2604;

    localparam logic [7:0]  POS_ACK  = 8'hA5;
    localparam logic [15:0] CAL_GYRO = 16'h2000;
    localparam logic [3:0]  MOVE_OP  = 4'h4;

    function automatic logic [15:0] move_cmd(input logic [11:0] arg);
        return {MOVE_OP, arg};
    endfunction

endpackage

// File: rtl/remote_comm_uart.sv
// uart: 8N1 transmitter and receiver sharing one bit period.
// tx_done is high in the last clock of the stop bit.
module uart
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx,
    input  logic       rx,
    input  logic       clr_rdy,
    output logic       rx_rdy,
    output logic [7:0] rx_data
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    logic          tx_busy;
    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_shift;
    logic          tx_q;
    logic          tx_bit_end;

    logic          sync1;
    logic          sync2;
    logic          sync3;
    logic          rx_busy;
    logic [CW-1:0] rx_baud;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_data_q;
    logic          rx_rdy_q;
    logic          fall;
    logic          start_det;
    logic          rx_smp;
    logic          stop_smp;

    assign tx_bit_end = tx_busy && (tx_baud == FULL);
    assign tx_done    = tx_bit_end && (tx_bit == 4'd9);
    assign tx         = tx_q;

    assign fall      = sync3 & ~sync2;
    assign start_det = ~rx_busy & fall;
    assign rx_smp    = rx_busy &&
                       (rx_baud == ((rx_bit == 4'd0) ? HALF : FULL));
    assign stop_smp  = rx_smp && (rx_bit == 4'd9);
    assign rx_rdy    = rx_rdy_q;
    assign rx_data   = rx_data_q;

    // Transmit shifter: start bit on load, then data LSB first, then stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_busy  <= 1'b0;
            tx_baud  <= '0;
            tx_bit   <= 4'd0;
            tx_shift <= '1;
            tx_q     <= 1'b1;
        end else if (trmt) begin
            tx_busy  <= 1'b1;
            tx_baud  <= '0;
            tx_bit   <= 4'd0;
            tx_shift <= {1'b1, tx_data};
            tx_q     <= 1'b0;
        end else if (tx_bit_end) begin
            tx_baud <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
                tx_bit  <= 4'd0;
            end else begin
                tx_q     <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bit   <= tx_bit + 4'd1;
            end
        end else if (tx_busy) begin
            tx_baud <= tx_baud + 1'b1;
        end
    end

    // Receiver: synchronise RX, find the start edge, sample mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync3    <= 1'b1;
            rx_busy  <= 1'b0;
            rx_baud  <= '0;
            rx_bit   <= 4'd0;
            rx_shift <= '0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            sync3 <= sync2;
            if (start_det) begin
                rx_busy <= 1'b1;
                rx_baud <= '0;
                rx_bit  <= 4'd0;
            end else if (rx_smp) begin
                rx_baud <= '0;
                if ((rx_bit == 4'd0) && sync2) begin
                    rx_busy <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                end else if (rx_bit != 4'd0) begin
                    rx_shift <= {sync2, rx_shift[7:1]};
                end
                rx_bit <= rx_bit + 4'd1;
            end else if (rx_busy) begin
                rx_baud <= rx_baud + 1'b1;
            end
        end
    end

    // Deliver the byte at the stop sample regardless of the stop value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rdy_q  <= 1'b0;
            rx_data_q <= 8'h00;
        end else if (stop_smp) begin
            rx_rdy_q  <= 1'b1;
            rx_data_q <= rx_shift;
        end else if (clr_rdy || start_det) begin
            rx_rdy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two UART bytes, high first,
// and captures the robot's one-byte response.
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    state_t     state;
    state_t     nxt;
    logic [7:0] lo_byte;
    logic       cmd_snt_q;
    logic       trmt;
    logic [7:0] tx_byte;
    logic       accept;
    logic       tx_done;

    assign cmd_snt = cmd_snt_q;

    uart #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk    (clk),
        .rst    (rst),
        .trmt   (trmt),
        .tx_data(tx_byte),
        .tx_done(tx_done),
        .tx     (TX),
        .rx     (RX),
        .clr_rdy(accept),
        .rx_rdy (resp_rdy),
        .rx_data(resp)
    );

    // Command FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next state and byte hand-off; the low byte follows the high
    // byte's stop bit with no idle gap.
    always_comb begin
        nxt     = state;
        trmt    = 1'b0;
        tx_byte = cmd[15:8];
        accept  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (snd_cmd) begin
                    accept = 1'b1;
                    trmt   = 1'b1;
                    nxt    = TX_HI;
                end
            end
            TX_HI: begin
                if (tx_done) begin
                    trmt    = 1'b1;
                    tx_byte = lo_byte;
                    nxt     = TX_LO;
                end
            end
            TX_LO: begin
                if (tx_done) begin
                    nxt = DONE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Low-byte capture and the sticky completion flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_byte   <= 8'h00;
            cmd_snt_q <= 1'b0;
        end else if (accept) begin
            lo_byte   <= cmd[7:0];
            cmd_snt_q <= 1'b0;
        end else if ((state == TX_LO) && tx_done) begin
            cmd_snt_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed checks of command send, response receive,
// glitch rejection and mid-transfer reset.
module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int BD    = 64;
    localparam int LAT   = 20 * BD + 1;
    localparam int LIMIT = 25 * BD;

    logic        clk;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    int unsigned n_chk;
    int unsigned n_fail;
    logic [7:0]  rxq[$];

    remote_comm #(
        .BAUD_DIV(BD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .TX      (TX),
        .cmd     (cmd),
        .snd_cmd (snd_cmd),
        .cmd_snt (cmd_snt),
        .resp_rdy(resp_rdy),
        .resp    (resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench UART receiver decoding TX into rxq.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge TX);
            repeat (BD / 2) @(negedge clk);
            if (TX == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BD) @(negedge clk);
                rxq.push_back(b);
            end
        end
    end

    // Called at a negedge; returns clocks from snd_cmd to cmd_snt.
    task automatic send_cmd(input logic [15:0] c, input logic [15:0] c_after,
                            input int extra, output int lat,
                            output logic tx1, output logic snt1,
                            output logic rdy1);
        cmd     = c;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        cmd     = c_after;
        tx1     = TX;
        snt1    = cmd_snt;
        rdy1    = resp_rdy;
        lat     = 1;
        while (!cmd_snt && lat < LIMIT) begin
            snd_cmd = (lat == extra);
            @(negedge clk);
            lat++;
        end
        snd_cmd = 1'b0;
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop,
                            output logic rdy_mid);
        logic [9:0] frame;
        frame   = {stop, d, 1'b0};
        rdy_mid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) rdy_mid = resp_rdy;
            RX = frame[i];
            repeat (BD) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        RX      = 1'b1;
        snd_cmd = 1'b0;
        cmd     = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_chk += 4;
            if (TX !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_tx cyc %0d got %b want 1", i, TX);
            end
            if (cmd_snt !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_cmd_snt cyc %0d got %b want 0", i, cmd_snt);
            end
            if (resp_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_resp_rdy cyc %0d got %b want 0", i, resp_rdy);
            end
            if (resp !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_resp cyc %0d got %h want 00", i, resp);
            end
        end
    endtask

    task automatic test_cal_gyro;
        int   lat;
        logic tx1, snt1, rdy1;
        rxq.delete();
        n_chk++;
        if (TX !== 1'b1) begin
            n_fail++;
            $display("FAIL gyro_idle_tx got %b want 1", TX);
        end
        send_cmd(CAL_GYRO, CAL_GYRO, 0, lat, tx1, snt1, rdy1);
        n_chk++;
        if (tx1 !== 1'b0) begin
            n_fail++;
            $display("FAIL gyro_start_bit got %b want 0", tx1);
        end
        n_chk++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL gyro_latency got %0d want %0d", lat, LAT);
        end
        repeat (2 * BD) @(negedge clk);
        n_chk++;
        if (rxq.size() != 2) begin
            n_fail++;
            $display("FAIL gyro_count got %0d want 2", rxq.size());
        end else begin
            n_chk++;
            if (rxq[0] !== 8'h20 || rxq[1] !== 8'h00) begin
                n_fail++;
                $display("FAIL gyro_bytes got %h %h want 20 00", rxq[0], rxq[1]);
            end
        end
        n_chk++;
        if (cmd_snt !== 1'b1) begin
            n_fail++;
            $display("FAIL gyro_snt_hold got %b want 1", cmd_snt);
        end
    endtask

    task automatic test_ignore;
        int   lat;
        logic tx1, snt1, rdy1;
        rxq.delete();
        send_cmd(16'h47F3, 16'hFFFF, 5 * BD, lat, tx1, snt1, rdy1);
        n_chk++;
        if (snt1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_snt_clear got %b want 0", snt1);
        end
        n_chk++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL ign_latency got %0d want %0d", lat, LAT);
        end
        repeat (2 * BD) @(negedge clk);
        n_chk++;
        if (rxq.size() != 2) begin
            n_fail++;
            $display("FAIL ign_count got %0d want 2", rxq.size());
        end else begin
            n_chk++;
            if (rxq[0] !== 8'h47 || rxq[1] !== 8'hF3) begin
                n_fail++;
                $display("FAIL ign_bytes got %h %h want 47 F3", rxq[0], rxq[1]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int   lat;
        logic tx1, snt1, rdy1;
        logic bad;
        rxq.delete();
        send_cmd(16'h1C2D, 16'h1C2D, 20 * BD, lat, tx1, snt1, rdy1);
        n_chk++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL b2b_latency got %0d want %0d", lat, LAT);
        end
        bad = 1'b0;
        for (int i = 0; i < 3 * BD; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_snt !== 1'b1) bad = 1'b1;
        end
        n_chk++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_edge_snd got restart want idle");
        end
        n_chk++;
        if (rxq.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 2", rxq.size());
        end
    endtask

    task automatic test_resp;
        int   lat;
        logic tx1, snt1, rdy1, mid;
        drive_rx(POS_ACK, 1'b1, mid);
        n_chk++;
        if (mid !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_early got %b want 0", mid);
        end
        n_chk++;
        if (resp_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_rdy got %b want 1", resp_rdy);
        end
        n_chk++;
        if (resp !== 8'hA5) begin
            n_fail++;
            $display("FAIL resp_val got %h want a5", resp);
        end
        rxq.delete();
        send_cmd(16'h4010, 16'h4010, 0, lat, tx1, snt1, rdy1);
        n_chk++;
        if (rdy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_clr got %b want 0", rdy1);
        end
        n_chk++;
        if (resp !== 8'hA5) begin
            n_fail++;
            $display("FAIL resp_keep got %h want a5", resp);
        end
        repeat (2 * BD) @(negedge clk);
    endtask

    task automatic test_glitch;
        logic mid;
        RX = 1'b0;
        repeat (BD / 2) @(negedge clk);
        RX = 1'b1;
        repeat (12 * BD) @(negedge clk);
        n_chk++;
        if (resp_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_rdy got %b want 0", resp_rdy);
        end
        n_chk++;
        if (resp !== 8'hA5) begin
            n_fail++;
            $display("FAIL glitch_resp got %h want a5", resp);
        end
        drive_rx(8'h5A, 1'b0, mid);
        repeat (BD) @(negedge clk);
        n_chk++;
        if (resp_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL badstop_rdy got %b want 1", resp_rdy);
        end
        n_chk++;
        if (resp !== 8'h5A) begin
            n_fail++;
            $display("FAIL badstop_resp got %h want 5a", resp);
        end
    endtask

    task automatic test_duplex;
        int   lat;
        logic tx1, snt1, rdy1, mid;
        rxq.delete();
        fork
            send_cmd(move_cmd(12'h123), move_cmd(12'h123), 0,
                     lat, tx1, snt1, rdy1);
            begin
                repeat (3 * BD) @(negedge clk);
                drive_rx(8'h3C, 1'b1, mid);
            end
        join
        repeat (2 * BD) @(negedge clk);
        n_chk++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL dup_latency got %0d want %0d", lat, LAT);
        end
        n_chk++;
        if (resp_rdy !== 1'b1 || resp !== 8'h3C) begin
            n_fail++;
            $display("FAIL dup_resp got %b/%h want 1/3c", resp_rdy, resp);
        end
        n_chk++;
        if (rxq.size() != 2) begin
            n_fail++;
            $display("FAIL dup_count got %0d want 2", rxq.size());
        end else begin
            n_chk++;
            if (rxq[0] !== 8'h41 || rxq[1] !== 8'h23) begin
                n_fail++;
                $display("FAIL dup_bytes got %h %h want 41 23", rxq[0], rxq[1]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int   lat;
        logic tx1, snt1, rdy1;
        logic bad;
        cmd     = 16'h5500;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (15 * BD - 1) @(negedge clk);
        n_chk++;
        if (TX !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_pre_tx got %b want 0", TX);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (TX !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_tx got %b want 1", TX);
        end
        n_chk++;
        if (cmd_snt !== 1'b0 || resp_rdy !== 1'b0 || resp !== 8'h00) begin
            n_fail++;
            $display("FAIL rmid_outs got %b/%b/%h want 0/0/00",
                     cmd_snt, resp_rdy, resp);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12 * BD; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_snt !== 1'b0) bad = 1'b1;
        end
        n_chk++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_quiet got activity want idle");
        end
        rxq.delete();
        send_cmd(CAL_GYRO, CAL_GYRO, 0, lat, tx1, snt1, rdy1);
        repeat (2 * BD) @(negedge clk);
        n_chk++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL rmid_latency got %0d want %0d", lat, LAT);
        end
        n_chk++;
        if (rxq.size() != 2) begin
            n_fail++;
            $display("FAIL rmid_count got %0d want 2", rxq.size());
        end else begin
            n_chk++;
            if (rxq[0] !== 8'h20 || rxq[1] !== 8'h00) begin
                n_fail++;
                $display("FAIL rmid_bytes got %h %h want 20 00", rxq[0], rxq[1]);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_cal_gyro();
        test_ignore();
        test_back_to_back();
        test_resp();
        test_glitch();
        test_duplex();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
